// File: rtl/de2_hex_pkg.sv
// de2_hex_pkg: register map, CTRL field positions and segment decode table for the DE2 hex controller.
package de2_hex_pkg;
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_BRIGHT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN_LSB    = 0;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_GEN_BIT   = 16;
    localparam int CTRL_SYNC_BIT  = 17;

    // Active-high gfedcba, indexed by nibble value (entry 0 is the rightmost).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/de2_hex_digit_enc.sv
// de2_hex_digit_enc: hex nibble to active-high seven-segment pattern (bit 0 = a).
module de2_hex_digit_enc
    import de2_hex_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SEG_LUT[nibble_i];
endmodule

// File: rtl/de2_pio_hex_ctrl.sv
// de2_pio_hex_ctrl: Avalon-MM seven-segment controller with per-digit
// enable/blink masks, blink prescaler and 16-level PWM brightness.
module de2_pio_hex_ctrl
    import de2_hex_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] out_port
);
    localparam int ND = NUM_DIGITS;
    localparam int OW = 7 * NUM_DIGITS;
    localparam int PW = $clog2(BLINK_DIV);

    logic [4*ND-1:0] data_q;
    logic [ND-1:0]   en_q, blink_q;
    logic            gen_q, phase_q;
    logic [3:0]      bright_q, pwm_q;
    logic [PW-1:0]   cnt_q;
    logic [OW-1:0]   seg_raw, out_d, out_q;
    logic            wr, sync, wrap, pwm_on;
    logic            unused_wd;

    assign unused_wd = ^writedata;
    assign wr        = chipselect & ~write_n;
    assign sync      = wr && address == ADDR_CTRL && writedata[CTRL_SYNC_BIT];
    assign wrap      = cnt_q == PW'(BLINK_DIV - 1);
    assign pwm_on    = pwm_q <= bright_q;

    for (genvar i = 0; i < ND; i++) begin : g_dig
        logic [6:0] seg;
        de2_hex_digit_enc u_enc (
            .nibble_i(data_q[4*i +: 4]),
            .seg_o   (seg)
        );
        assign seg_raw[7*i +: 7] = (gen_q & en_q[i] & pwm_on & ~(blink_q[i] & phase_q)) ? seg : 7'd0;
    end

    assign out_d    = ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign out_port = out_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[4*ND-1:0] = data_q;
            ADDR_CTRL: begin
                readdata[CTRL_EN_LSB +: ND]    = en_q;
                readdata[CTRL_BLINK_LSB +: ND] = blink_q;
                readdata[CTRL_GEN_BIT]         = gen_q;
            end
            ADDR_BRIGHT: readdata[3:0] = bright_q;
            default:     readdata[0] = phase_q;
        endcase
    end

    // A blink_sync strobe overrides a coincident prescaler wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            en_q     <= '1;
            blink_q  <= '0;
            gen_q    <= 1'b1;
            bright_q <= 4'hF;
            pwm_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            out_q    <= {OW{ACTIVE_LOW}};
        end else begin
            pwm_q   <= pwm_q + 4'd1;
            cnt_q   <= (sync || wrap) ? '0 : cnt_q + 1'b1;
            phase_q <= sync ? 1'b0 : phase_q ^ wrap;
            out_q   <= out_d;
            if (wr && address == ADDR_DATA)
                data_q <= writedata[4*ND-1:0];
            if (wr && address == ADDR_CTRL) begin
                en_q    <= writedata[CTRL_EN_LSB +: ND];
                blink_q <= writedata[CTRL_BLINK_LSB +: ND];
                gen_q   <= writedata[CTRL_GEN_BIT];
            end
            if (wr && address == ADDR_BRIGHT)
                bright_q <= writedata[3:0];
        end
    end
endmodule

// File: tb/tb_de2_pio_hex_ctrl.sv
// tb_de2_pio_hex_ctrl: directed and random register traffic checked against
// a time-indexed behavioural model of the display.
module tb_de2_pio_hex_ctrl;
    localparam int BD = 8;

    logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [27:0] out_port;

    int total = 0, bad = 0;
    int k, s;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_en, m_bl, m_br;
    logic        m_gen;
    logic [27:0] exp_o;
    logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    de2_pio_hex_ctrl #(.NUM_DIGITS(4), .BLINK_DIV(BD), .ACTIVE_LOW(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // k = edges since reset release, s = edge count at the last blink_sync.
    function automatic logic phase_now();
        return ((k - s) / BD) % 2 == 1;
    endfunction

    function automatic logic [27:0] model_out();
        logic [27:0] r = '1;
        for (int i = 0; i < 4; i++)
            if (m_gen && m_en[i] && (k % 16) <= m_br && !(m_bl[i] && phase_now()))
                r[7*i +: 7] = ~lut[m_dig[i]];
        return r;
    endfunction

    function automatic logic [31:0] model_rd(logic [1:0] a);
        case (a)
            2'd0:    return {16'b0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
            2'd1:    return {15'b0, m_gen, 4'b0, m_bl, 4'b0, m_en};
            2'd2:    return {28'b0, m_br};
            default: return {31'b0, phase_now()};
        endcase
    endfunction

    task automatic model_reset();
        k = 0;
        s = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_en  = 4'hF;
        m_bl  = 4'h0;
        m_br  = 4'hF;
        m_gen = 1'b1;
    endtask

    task automatic tick();
        #1 check("rd", readdata, model_rd(address));
        @(posedge clk);
        exp_o = model_out();
        if (chipselect && !write_n)
            case (address)
                2'd0: for (int i = 0; i < 4; i++) m_dig[i] = writedata[4*i +: 4];
                2'd1: begin
                    m_en  = writedata[3:0];
                    m_bl  = writedata[11:8];
                    m_gen = writedata[16];
                    if (writedata[17]) s = k + 1;
                end
                2'd2: m_br = writedata[3:0];
                default: ;
            endcase
        k++;
        #1 check("out", {4'b0, out_port}, {4'b0, exp_o});
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [1:0]  ra;
        logic [31:0] rd;
        model_reset();
        #12;
        check("rst_out", {4'b0, out_port}, 32'h0FFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 check("rst_rd", readdata, model_rd(2'(a)));
        end
        address = 2'd0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("first", {4'b0, out_port}, 32'h0810_2040);

        wr(2'd0, 32'h0000_A18F);
        idle(3);
        #1 check("data_rd", readdata, 32'h0000_A18F);
        wr(2'd1, 32'h0001_0005);
        idle(4);
        wr(2'd1, 32'h0000_0000);
        idle(3);
        wr(2'd1, 32'h0001_020F);
        address = 2'd3;
        idle(21);
        wr(2'd1, 32'h0003_020F);
        address = 2'd3;
        idle(20);
        wr(2'd2, 32'h3);
        idle(34);
        wr(2'd2, 32'h0);
        idle(34);
        wr(2'd2, 32'hF);
        idle(5);
        wr(2'd0, 32'hFFFF_FFFF);
        #1 check("data_clip", readdata, 32'h0000_FFFF);
        wr(2'd3, 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            tick();
        end

        #3 reset_n = 1'b0;
        address = 2'd3;
        #1 check("midrst_out", {4'b0, out_port}, 32'h0FFF_FFFF);
        check("midrst_status", readdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        repeat (500) begin
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                ra = 2'($urandom_range(0, 3));
                rd = $urandom;
                if (ra == 2'd1) begin
                    rd[16] = ($urandom_range(0, 3) != 0);
                    rd[17] = ($urandom_range(0, 5) == 0);
                end
                wr(ra, rd);
                address = 2'($urandom_range(0, 3));
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
